mc_lsu_bridge: RTL and testbench

- Parametrised load/store bridge between the multicycle core controller/datapath and a variable-latency memory with a valid/ready handshake.
- Replaces the fixed single-cycle, word-only memory port.
- Adds byte/halfword/word (and doubleword when XLEN=64) accesses, byte strobes, sign/zero extension, misalignment and illegal-size detection, and a wait-state timeout.
- The controller stalls on cpu_busy and advances on cpu_done.

---
 rtl/mc_lsu_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_mc_lsu_bridge.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_lsu_bridge.sv
// -----------------------------------------------------------------------------
// mc_lsu_bridge
//
// Load/store bridge between the multicycle core controller/datapath and a
// variable-latency memory. Decodes RISC-V load/store funct3, produces
// lane-aligned address/strobes/data, extends load data, and reports
// misaligned, illegal-size and wait-state timeout faults.
//
// Handshake: mem_valid is raised in REQ and mem_we/mem_addr/mem_wstrb/
// mem_wdata stay constant until a cycle where mem_valid & mem_ready are both
// high; that cycle completes the transfer (and carries mem_rdata for loads).
// On the CPU side, cpu_req is only looked at while cpu_busy is low; the
// controller waits for a one-cycle cpu_done or cpu_fault pulse.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cpu_req/we/funct3   access request, direction and RISC-V size code
//   cpu_addr/wdata      byte address, right-aligned store data
//   cpu_rdata           extended load data (holds until next completed load)
//   cpu_busy/done/fault access in progress, completion and fault pulses
//   fault_cause         01 misaligned, 10 illegal funct3, 11 timeout
//   mem_valid/we/addr   memory request, write enable, lane-aligned address
//   mem_wstrb/wdata     byte strobes and lane-shifted store data
//   mem_rdata/ready     memory read data and accept/complete
//   dbg_state           current FSM state (IDLE=0, REQ=1, DONE=2, FAULT=3)
// -----------------------------------------------------------------------------
module mc_lsu_bridge #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_funct3,
    input  logic [XLEN-1:0]   cpu_addr,
    input  logic [XLEN-1:0]   cpu_wdata,
    output logic [XLEN-1:0]   cpu_rdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_fault,
    output logic [1:0]        fault_cause,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        dbg_state
);

    localparam int SW = XLEN / 8;
    localparam int LB = $clog2(SW);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // Data mask for an access size (funct3[1:0]: 0=B, 1=H, 2=W, 3=D).
    function automatic logic [XLEN-1:0] f_dmask(input logic [1:0] sz);
        case (sz)
            2'd0:    f_dmask = XLEN'(8'hFF);
            2'd1:    f_dmask = XLEN'(16'hFFFF);
            2'd2:    f_dmask = XLEN'(32'hFFFF_FFFF);
            default: f_dmask = {XLEN{1'b1}};
        endcase
    endfunction

    // Strobe pattern for an access size before shifting into its lane.
    function automatic logic [SW-1:0] f_smask(input logic [1:0] sz);
        case (sz)
            2'd0:    f_smask = SW'(1);
            2'd1:    f_smask = SW'(3);
            2'd2:    f_smask = SW'(15);
            default: f_smask = {SW{1'b1}};
        endcase
    endfunction

    state_t           r_state;
    logic             r_we;
    logic [XLEN-1:0]  r_addr;
    logic [SW-1:0]    r_wstrb;
    logic [XLEN-1:0]  r_wdata;
    logic [LB-1:0]    r_lane;
    logic [1:0]       r_size;
    logic             r_uns;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_rdata;
    logic [1:0]       r_cause;

    logic [1:0]       w_size;
    logic [LB-1:0]    w_lane;
    logic             w_legal;
    logic             w_misal;
    logic [SW-1:0]    w_wstrb;
    logic [XLEN-1:0]  w_wdata;
    logic [XLEN-1:0]  w_rsh;
    logic [XLEN-1:0]  w_rdm;
    logic             w_sbit;
    logic [XLEN-1:0]  w_ld;
    logic             w_tmo;

    assign w_size  = cpu_funct3[1:0];
    assign w_lane  = cpu_addr[LB-1:0];
    assign w_wstrb = f_smask(w_size) << w_lane;
    assign w_wdata = (cpu_wdata & f_dmask(w_size)) << {w_lane, 3'b000};

    // 011 (D) and 110 (WU) only exist on a 64-bit datapath; 1xx are loads only.
    always_comb begin
        w_legal = 1'b0;
        case (cpu_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b011:                 w_legal = (XLEN == 64);
            3'b100, 3'b101:         w_legal = ~cpu_we;
            3'b110:                 w_legal = ~cpu_we & (XLEN == 64);
            default:                w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_misal = 1'b0;
        case (w_size)
            2'd1:    w_misal = cpu_addr[0];
            2'd2:    w_misal = |cpu_addr[1:0];
            2'd3:    w_misal = |cpu_addr[2:0];
            default: w_misal = 1'b0;
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then extend.
    assign w_rsh = mem_rdata >> {r_lane, 3'b000};
    assign w_rdm = f_dmask(r_size);

    always_comb begin
        w_sbit = 1'b0;
        case (r_size)
            2'd0:    w_sbit = w_rsh[7];
            2'd1:    w_sbit = w_rsh[15];
            2'd2:    w_sbit = w_rsh[31];
            default: w_sbit = w_rsh[XLEN-1];
        endcase
    end

    assign w_ld  = (w_rsh & w_rdm) | ((w_sbit & ~r_uns) ? ~w_rdm : '0);

    // Fires on the last permitted wait cycle so mem_valid lasts exactly TIMEOUT cycles.
    assign w_tmo = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_lane  <= '0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_cause <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        if (!w_legal) begin
                            r_cause <= 2'b10;
                            r_state <= S_FAULT;
                        end else if (w_misal) begin
                            r_cause <= 2'b01;
                            r_state <= S_FAULT;
                        end else begin
                            r_we    <= cpu_we;
                            r_addr  <= {cpu_addr[XLEN-1:LB], {LB{1'b0}}};
                            r_wstrb <= cpu_we ? w_wstrb : '0;
                            r_wdata <= cpu_we ? w_wdata : '0;
                            r_lane  <= w_lane;
                            r_size  <= w_size;
                            r_uns   <= cpu_funct3[2];
                            r_cnt   <= '0;
                            r_cause <= 2'b00;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        if (!r_we) begin
                            r_rdata <= w_ld;
                        end
                        r_state <= S_DONE;
                    end else if (w_tmo) begin
                        r_cause <= 2'b11;
                        r_state <= S_FAULT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // All CPU/memory outputs come straight from state and latched registers.
    assign mem_valid   = (r_state == S_REQ);
    assign cpu_busy    = (r_state != S_IDLE);
    assign cpu_done    = (r_state == S_DONE);
    assign cpu_fault   = (r_state == S_FAULT);
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wstrb   = r_wstrb;
    assign mem_wdata   = r_wdata;
    assign cpu_rdata   = r_rdata;
    assign fault_cause = r_cause;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_mc_lsu_bridge.sv
module tb_mc_lsu_bridge;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // index 0: XLEN=32, TIMEOUT=8 ; index 1: XLEN=64, TIMEOUT=0
  logic        rst      [2];
  logic        i_req    [2];
  logic        i_we     [2];
  logic [2:0]  i_f3     [2];
  logic [63:0] i_addr   [2];
  logic [63:0] i_wdata  [2];
  logic [63:0] i_mrdata [2];
  logic        i_ready  [2];
  int          dly      [2];

  logic [63:0] o_rdata  [2];
  logic        o_busy   [2];
  logic        o_done   [2];
  logic        o_fault  [2];
  logic [1:0]  o_cause  [2];
  logic        o_valid  [2];
  logic        o_we     [2];
  logic [63:0] o_addr   [2];
  logic [7:0]  o_wstrb  [2];
  logic [63:0] o_wdata  [2];
  logic [1:0]  o_state  [2];

  logic [31:0] w32_rdata, w32_addr, w32_wdata;
  logic [3:0]  w32_wstrb;

  assign o_rdata[0] = {32'b0, w32_rdata};
  assign o_addr[0]  = {32'b0, w32_addr};
  assign o_wdata[0] = {32'b0, w32_wdata};
  assign o_wstrb[0] = {4'b0, w32_wstrb};

  mc_lsu_bridge #(.XLEN(32), .TIMEOUT(8), .CNT_W(16)) u_dut32 (
    .clk(clk), .reset(rst[0]), .cpu_req(i_req[0]), .cpu_we(i_we[0]),
    .cpu_funct3(i_f3[0]), .cpu_addr(i_addr[0][31:0]), .cpu_wdata(i_wdata[0][31:0]),
    .cpu_rdata(w32_rdata), .cpu_busy(o_busy[0]), .cpu_done(o_done[0]),
    .cpu_fault(o_fault[0]), .fault_cause(o_cause[0]), .mem_valid(o_valid[0]),
    .mem_we(o_we[0]), .mem_addr(w32_addr), .mem_wstrb(w32_wstrb),
    .mem_wdata(w32_wdata), .mem_rdata(i_mrdata[0][31:0]), .mem_ready(i_ready[0]),
    .dbg_state(o_state[0])
  );

  mc_lsu_bridge #(.XLEN(64), .TIMEOUT(0), .CNT_W(16)) u_dut64 (
    .clk(clk), .reset(rst[1]), .cpu_req(i_req[1]), .cpu_we(i_we[1]),
    .cpu_funct3(i_f3[1]), .cpu_addr(i_addr[1]), .cpu_wdata(i_wdata[1]),
    .cpu_rdata(o_rdata[1]), .cpu_busy(o_busy[1]), .cpu_done(o_done[1]),
    .cpu_fault(o_fault[1]), .fault_cause(o_cause[1]), .mem_valid(o_valid[1]),
    .mem_we(o_we[1]), .mem_addr(o_addr[1]), .mem_wstrb(o_wstrb[1]),
    .mem_wdata(o_wdata[1]), .mem_rdata(i_mrdata[1]), .mem_ready(i_ready[1]),
    .dbg_state(o_state[1])
  );

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    logic        fault;
    logic [1:0]  cause;
    logic [63:0] rdata;
    logic        we;
    logic [63:0] maddr;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
    int          vcyc;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- memory model
  int wcnt[2];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (o_valid[d] === 1'b1) begin
        i_ready[d] = (wcnt[d] >= dly[d]);
        wcnt[d]++;
      end else begin
        i_ready[d] = 1'b0;
        wcnt[d] = 0;
      end
    end
  end

  // handshake seen at each rising edge, used to check cpu_done latency
  logic hs_q[2];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) hs_q[d] <= o_valid[d] & i_ready[d];
  end

  // ---------------------------------------------------------------- monitor
  int          vcnt     [2];
  logic [63:0] cap_addr [2];
  logic [63:0] cap_wdata[2];
  logic [7:0]  cap_wstrb[2];
  logic        cap_we   [2];
  logic        unstable [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        vcnt[d] = 0;
        unstable[d] = 1'b0;
      end else begin
        if (o_valid[d]) begin
          if (vcnt[d] == 0) begin
            cap_addr[d] = o_addr[d];
            cap_wdata[d] = o_wdata[d];
            cap_wstrb[d] = o_wstrb[d];
            cap_we[d] = o_we[d];
          end else if (cap_addr[d] !== o_addr[d] || cap_wdata[d] !== o_wdata[d] ||
                       cap_wstrb[d] !== o_wstrb[d] || cap_we[d] !== o_we[d]) begin
            unstable[d] = 1'b1;
          end
          vcnt[d]++;
        end
        if (o_valid[d] || o_done[d] || o_fault[d]) chk("busy", {63'b0, o_busy[d]}, 64'd1);
        if (o_done[d] || o_fault[d]) begin
          exp_t e;
          int qs;
          qs = (d == 0) ? exp_q0.size() : exp_q1.size();
          if (qs == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse dut%0d: done=%b fault=%b with no expected access", d, o_done[d], o_fault[d]);
          end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk("done_fault", {62'b0, o_done[d], o_fault[d]}, {62'b0, ~e.fault, e.fault});
            chk("fault_cause", {62'b0, o_cause[d]}, {62'b0, e.cause});
            chk("cpu_rdata", o_rdata[d], e.rdata);
            chk("valid_cycles", 64'(vcnt[d]), 64'(e.vcyc));
            chk("req_stable", {63'b0, unstable[d]}, 64'd0);
            if (!e.fault) chk("done_latency", {63'b0, hs_q[d]}, 64'd1);
            if (e.vcyc > 0) begin
              chk("mem_we", {63'b0, cap_we[d]}, {63'b0, e.we});
              chk("mem_addr", cap_addr[d], e.maddr);
              chk("mem_wstrb", {56'b0, cap_wstrb[d]}, {56'b0, e.wstrb});
              if (e.we) chk("mem_wdata", cap_wdata[d], e.wdata);
            end
          end
          vcnt[d] = 0;
          unstable[d] = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic issue(input int d, input logic we, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] mrdata, input int mdly,
                       input logic fault, input logic [1:0] cause,
                       input logic [63:0] erdata, input logic [63:0] maddr,
                       input logic [7:0] wstrb, input logic [63:0] ewdata,
                       input int vcyc);
    exp_t e;
    bit seen;
    e.fault = fault; e.cause = cause; e.rdata = erdata; e.we = we;
    e.maddr = maddr; e.wstrb = wstrb; e.wdata = ewdata; e.vcyc = vcyc;
    if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    i_mrdata[d] = mrdata;
    dly[d] = mdly;
    @(negedge clk);
    i_req[d] = 1'b1; i_we[d] = we; i_f3[d] = f3; i_addr[d] = addr; i_wdata[d] = wdata;
    @(negedge clk);
    i_req[d] = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_done[d] || o_fault[d]) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL wait_timeout dut%0d: no done/fault within 40 cycles, addr %h", d, addr);
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input int d, input string nm);
    chk({nm, "_rdata"}, o_rdata[d], 64'd0);
    chk({nm, "_ctrl"}, {55'b0, o_busy[d], o_done[d], o_fault[d], o_cause[d], o_valid[d], o_we[d], o_state[d]}, 64'd0);
    chk({nm, "_addr"}, o_addr[d], 64'd0);
    chk({nm, "_wstrb"}, {56'b0, o_wstrb[d]}, 64'd0);
    chk({nm, "_wdata"}, o_wdata[d], 64'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; i_req[d] = 1'b0; i_we[d] = 1'b0; i_f3[d] = 3'd0;
      i_addr[d] = '0; i_wdata[d] = '0; i_mrdata[d] = '0; i_ready[d] = 1'b0; dly[d] = 0;
    end
    repeat (3) @(negedge clk);
    chk_zero(0, "reset32");
    chk_zero(1, "reset64");
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);

    // ---- 32-bit DUT: d, we, f3, addr, wdata, mrdata, dly, fault, cause, rdata, maddr, wstrb, wdata, vcyc
    issue(0, 0, 3'b000, 64'h1003, 64'h0, 64'h80FF1234, 0, 0, 2'b00, 64'hFFFFFF80, 64'h1000, 8'h0, 64'h0, 1); // LB
    issue(0, 0, 3'b100, 64'h1003, 64'h0, 64'h80FF1234, 0, 0, 2'b00, 64'h00000080, 64'h1000, 8'h0, 64'h0, 1); // LBU
    issue(0, 1, 3'b001, 64'h2002, 64'h0000BEEF, 64'h0, 4, 0, 2'b00, 64'h00000080, 64'h2000, 8'hC, 64'hBEEF0000, 5); // SH
    issue(0, 0, 3'b010, 64'h3001, 64'h0, 64'h0, 0, 1, 2'b01, 64'h00000080, 64'h0, 8'h0, 64'h0, 0); // LW misaligned
    issue(0, 0, 3'b011, 64'h3000, 64'h0, 64'h0, 0, 1, 2'b10, 64'h00000080, 64'h0, 8'h0, 64'h0, 0); // LD on 32-bit
    issue(0, 0, 3'b010, 64'h4000, 64'h0, 64'h0, 1000, 1, 2'b11, 64'h00000080, 64'h4000, 8'h0, 64'h0, 8); // timeout
    issue(0, 0, 3'b010, 64'h4004, 64'h0, 64'h12345678, 1, 0, 2'b00, 64'h12345678, 64'h4004, 8'h0, 64'h0, 2); // LW clears cause
    issue(0, 0, 3'b001, 64'h5002, 64'h0, 64'h80017FFF, 0, 0, 2'b00, 64'hFFFF8001, 64'h5000, 8'h0, 64'h0, 1); // LH
    issue(0, 0, 3'b101, 64'h5002, 64'h0, 64'h80017FFF, 2, 0, 2'b00, 64'h00008001, 64'h5000, 8'h0, 64'h0, 3); // LHU
    issue(0, 1, 3'b000, 64'h6001, 64'h123456AB, 64'h0, 0, 0, 2'b00, 64'h00008001, 64'h6000, 8'h2, 64'h0000AB00, 1); // SB
    issue(0, 1, 3'b010, 64'h6004, 64'hDEADBEEF, 64'h0, 1, 0, 2'b00, 64'h00008001, 64'h6004, 8'hF, 64'hDEADBEEF, 2); // SW
    issue(0, 1, 3'b100, 64'h6000, 64'h0, 64'h0, 0, 1, 2'b10, 64'h00008001, 64'h0, 8'h0, 64'h0, 0); // store f3=100
    issue(0, 0, 3'b110, 64'h6000, 64'h0, 64'h0, 0, 1, 2'b10, 64'h00008001, 64'h0, 8'h0, 64'h0, 0); // LWU on 32-bit
    issue(0, 1, 3'b001, 64'h6001, 64'h0, 64'h0, 0, 1, 2'b01, 64'h00008001, 64'h0, 8'h0, 64'h0, 0); // SH misaligned

    // ---- 64-bit DUT
    issue(1, 0, 3'b110, 64'h8004, 64'h0, 64'hF0000000_00000000, 0, 0, 2'b00, 64'h00000000_F0000000, 64'h8000, 8'h0, 64'h0, 1); // LWU
    issue(1, 1, 3'b011, 64'h8000, 64'h01234567_89ABCDEF, 64'h0, 1, 0, 2'b00, 64'h00000000_F0000000, 64'h8000, 8'hFF, 64'h01234567_89ABCDEF, 2); // SD
    issue(1, 0, 3'b011, 64'h8008, 64'h0, 64'h80000000_00000001, 0, 0, 2'b00, 64'h80000000_00000001, 64'h8008, 8'h0, 64'h0, 1); // LD
    issue(1, 0, 3'b010, 64'h800C, 64'h0, 64'h87654321_00000000, 0, 0, 2'b00, 64'hFFFFFFFF_87654321, 64'h8008, 8'h0, 64'h0, 1); // LW upper
    issue(1, 1, 3'b011, 64'h8004, 64'h0, 64'h0, 0, 1, 2'b01, 64'hFFFFFFFF_87654321, 64'h0, 8'h0, 64'h0, 0); // SD misaligned
    issue(1, 0, 3'b111, 64'h8000, 64'h0, 64'h0, 0, 1, 2'b10, 64'hFFFFFFFF_87654321, 64'h0, 8'h0, 64'h0, 0); // f3=111

    // ---- reset in the second REQ cycle of a 32-bit load (no expected entry)
    dly[0] = 20;
    @(negedge clk);
    i_req[0] = 1'b1; i_we[0] = 1'b0; i_f3[0] = 3'b010; i_addr[0] = 64'h7000;
    @(negedge clk);
    i_req[0] = 1'b0;
    chk("abort_valid_c1", {63'b0, o_valid[0]}, 64'd1);
    @(negedge clk);
    chk("abort_valid_c2", {63'b0, o_valid[0]}, 64'd1);
    rst[0] = 1'b1;
    @(negedge clk);
    chk_zero(0, "abort");
    @(negedge clk);
    rst[0] = 1'b0;
    issue(0, 0, 3'b010, 64'h7008, 64'h0, 64'hCAFEF00D, 0, 0, 2'b00, 64'hCAFEF00D, 64'h7008, 8'h0, 64'h0, 1); // LW after reset

    repeat (3) @(negedge clk);
    chk("queue0_empty", 64'(exp_q0.size()), 64'd0);
    chk("queue1_empty", 64'(exp_q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global safety bound
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
